// File: rtl/lcd_message_driver.sv
// rtl/lcd_message_driver.sv - one-line LCD message renderer for the reaction-timer status
//
// Purpose:
//   Accepts a display request from the reaction-timer FSM, latches its status
//   flags and ReactionTime, converts ReactionTime to three BCD digits with a
//   fixed 9-step double-dabble, then writes a 16-character line to the LCD
//   character port under ready/valid flow control. It then acknowledges the
//   request.
//
// Configuration macro:
//   LCD_LEADING_ZERO_BLANK_EN - blank leading zero digits of the reaction time.
//
// Ports:
//   Clk           in   1  system clock, rising edge
//   Rst           in   1  asynchronous active-low reset
//   LCDUpdate     in   1  display request level, held until LCDAck
//   Cheat         in   1  status flag (highest priority)
//   Slow          in   1  status flag
//   Wait          in   1  status flag
//   ReactionTime  in   9  reaction time in ms
//   LCDAck        out  1  request complete, held until LCDUpdate falls
//   CharData      out  8  ASCII character
//   CharAddr      out  7  BASE_ADDR + character index
//   CharWrite     out  1  character valid
//   CharReady     in   1  LCD port can accept a character
//   Busy          out  1  high whenever not idle

module lcd_message_driver #(
  parameter int         LINE_LEN  = 16,
  parameter logic [6:0] BASE_ADDR = 7'h00
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       LCDUpdate,
  input  logic       Cheat,
  input  logic       Slow,
  input  logic       Wait,
  input  logic [8:0] ReactionTime,
  output logic       LCDAck,
  output logic [7:0] CharData,
  output logic [6:0] CharAddr,
  output logic       CharWrite,
  input  logic       CharReady,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, ACK} state_t;

  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

  state_t      state;
  logic        cheat_q;
  logic        slow_q;
  logic        wait_q;
  logic [8:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  step_q;
  logic [3:0]  idx_q;

  logic [11:0]  bcd_next;
  logic [127:0] line_cur;
  logic [127:0] line_first;

  // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dd_step(input logic [11:0] b, input logic in_bit);
    logic [11:0] a;
    for (int n = 0; n < 3; n++) begin
      a[4*n +: 4] = (b[4*n +: 4] >= 4'd5) ? b[4*n +: 4] + 4'd3 : b[4*n +: 4];
    end
    return {a[10:0], in_bit};
  endfunction

  // Full 16-character line, first character in the most significant byte.
  function automatic logic [127:0] build_line(input logic c, input logic s, input logic w,
                                              input logic [11:0] bcd);
    logic [7:0] h;
    logic [7:0] t;
    logic [7:0] u;
    h = 8'h30 + {4'h0, bcd[11:8]};
    t = 8'h30 + {4'h0, bcd[7:4]};
    u = 8'h30 + {4'h0, bcd[3:0]};
`ifdef LCD_LEADING_ZERO_BLANK_EN
    if (bcd[11:8] == 4'd0) begin
      h = 8'h20;
      if (bcd[7:4] == 4'd0) t = 8'h20;
    end
`else
`endif
    if (c)      return {"CHEATER!", {8{8'h20}}};
    else if (s) return {"TOO SLOW", {8{8'h20}}};
    else if (w) return {"WAIT...", {9{8'h20}}};
    else        return {"RT: ", h, t, u, " MS", {6{8'h20}}};
  endfunction

  function automatic logic [7:0] char_of(input logic [127:0] line, input logic [3:0] i);
    logic [6:0] lsb;
    lsb = {4'd15 - i, 3'b000};
    return line[lsb +: 8];
  endfunction

  // line_first uses the post-step BCD so index 0 is correct on the last CONVERT edge.
  always_comb begin
    bcd_next   = dd_step(bcd_q, bin_q[8]);
    line_cur   = build_line(cheat_q, slow_q, wait_q, bcd_q);
    line_first = build_line(cheat_q, slow_q, wait_q, bcd_next);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      LCDAck    <= 1'b0;
      CharWrite <= 1'b0;
      CharData  <= 8'h20;
      CharAddr  <= BASE_ADDR;
      Busy      <= 1'b0;
      cheat_q   <= 1'b0;
      slow_q    <= 1'b0;
      wait_q    <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      idx_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (LCDUpdate) begin
            cheat_q <= Cheat;
            slow_q  <= Slow;
            wait_q  <= Wait;
            bin_q   <= ReactionTime;
            bcd_q   <= '0;
            step_q  <= '0;
            Busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          // Runs all 9 steps even for flag messages so latency never varies.
          bcd_q  <= bcd_next;
          bin_q  <= {bin_q[7:0], 1'b0};
          step_q <= step_q + 4'd1;
          if (step_q == 4'd8) begin
            state     <= WRITE;
            idx_q     <= '0;
            CharWrite <= 1'b1;
            CharData  <= char_of(line_first, 4'd0);
            CharAddr  <= BASE_ADDR;
          end
        end
        WRITE: begin
          if (CharReady) begin
            if (idx_q == LAST_IDX) begin
              CharWrite <= 1'b0;
              LCDAck    <= 1'b1;
              state     <= ACK;
            end else begin
              idx_q    <= idx_q + 4'd1;
              CharData <= char_of(line_cur, idx_q + 4'd1);
              CharAddr <= BASE_ADDR + {3'b000, idx_q + 4'd1};
            end
          end
        end
        ACK: begin
          if (!LCDUpdate) begin
            LCDAck <= 1'b0;
            Busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
